led_sequencer: RTL and testbench

- Parametrised LED pattern sequencer for board-level status and heartbeat display.
- Replaces the fixed 4-LED walking-zero blinker.
- Runs entirely on clk, using a prescaler clock-enable; no derived clocks.
- Supports N LEDs, selectable polarity, four display modes, run/freeze control and a runtime speed select.

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/led_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Holds the mode/direction encodings and the counter-width helper.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_WALK   = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_BINARY = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 32'd1) begin
         return 32'd1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock-enable generator: tick pulses once every DIV enabled cycles.
// The count freezes while en is low and resumes from where it stopped.
module tick_prescaler
   import led_seq_pkg::*;
#(
   parameter int unsigned DIV = 32'd10000000
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

   logic [CW-1:0] cnt_r;
   logic          wrap_s;

   assign wrap_s = (cnt_r == LAST);
   assign tick   = en & wrap_s;

   // Prescaler counter, wraps at DIV-1 and holds while disabled.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= wrap_s ? '0 : cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Parametrised LED pattern sequencer: WALK, BOUNCE, BINARY and BLINK modes
// advancing every 2^speed prescaler ticks, with a registered, polarity-aware output.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned N_LED      = 32'd4,
   parameter int unsigned DIV        = 32'd10000000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [N_LED-1:0] led,
   output logic             adv
);

   localparam int unsigned PW = cnt_width(N_LED);
   localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 32'd1);
   localparam logic [N_LED-1:0] LED_OFF = ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

   logic             tick_s;
   logic             step_s;
   logic [2:0]       sc_r;
   logic [2:0]       sc_mask_s;

   mode_e            mode_s;
   mode_e            mode_q_r;
   logic             first_r;
   logic             load_s;

   // Held state is the state to be displayed on the next step.
   logic [PW-1:0]    pos_r,   pos_cur_s,   pos_nxt_s;
   dir_e             dir_r,   dir_cur_s,   dir_nxt_s;
   logic [N_LED-1:0] count_r, count_cur_s, count_nxt_s;
   logic             off_r,   off_cur_s,   off_nxt_s;
   logic [N_LED-1:0] pat_s;

   logic [N_LED-1:0] led_r;
   logic             adv_r;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk  (clk),
      .nrst (nrst),
      .en   (en),
      .tick (tick_s)
   );

   assign sc_mask_s = 3'((4'd1 << speed) - 4'd1);
   assign step_s    = tick_s & ((sc_r & sc_mask_s) == 3'd0);

   // Speed divider counting base ticks.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sc_r <= 3'd0;
      end else if (tick_s) begin
         sc_r <= sc_r + 3'd1;
      end else begin
         sc_r <= sc_r;
      end
   end

   // Pattern to show on this step and the state that follows it.
   always_comb begin
      mode_s = mode_e'(mode);
      load_s = first_r | (mode_s != mode_q_r);
      if (load_s) begin
         pos_cur_s   = '0;
         dir_cur_s   = DIR_UP;
         count_cur_s = '0;
         off_cur_s   = 1'b0;
      end else begin
         pos_cur_s   = pos_r;
         dir_cur_s   = dir_r;
         count_cur_s = count_r;
         off_cur_s   = off_r;
      end
      pat_s       = '0;
      pos_nxt_s   = pos_cur_s;
      dir_nxt_s   = dir_cur_s;
      count_nxt_s = count_cur_s;
      off_nxt_s   = off_cur_s;
      case (mode_s)
         MODE_WALK: begin
            pat_s[pos_cur_s] = 1'b1;
            pos_nxt_s = (pos_cur_s == POS_LAST) ? '0 : pos_cur_s + PW'(1);
         end
         MODE_BOUNCE: begin
            pat_s[pos_cur_s] = 1'b1;
            // Turn around at the ends so neither endpoint is shown twice.
            if (dir_cur_s == DIR_UP) begin
               if (pos_cur_s == POS_LAST) begin
                  dir_nxt_s = DIR_DOWN;
                  pos_nxt_s = (pos_cur_s == '0) ? '0 : pos_cur_s - PW'(1);
               end else begin
                  pos_nxt_s = pos_cur_s + PW'(1);
               end
            end else begin
               if (pos_cur_s == '0) begin
                  dir_nxt_s = DIR_UP;
                  pos_nxt_s = (pos_cur_s == POS_LAST) ? '0 : pos_cur_s + PW'(1);
               end else begin
                  pos_nxt_s = pos_cur_s - PW'(1);
               end
            end
         end
         MODE_BINARY: begin
            pat_s       = count_cur_s;
            count_nxt_s = count_cur_s + N_LED'(1);
         end
         MODE_BLINK: begin
            pat_s     = off_cur_s ? {N_LED{1'b0}} : {N_LED{1'b1}};
            off_nxt_s = ~off_cur_s;
         end
         default: begin
            pat_s = '0;
         end
      endcase
   end

   // Pattern state, output drive and advance pulse.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pos_r    <= '0;
         dir_r    <= DIR_UP;
         count_r  <= '0;
         off_r    <= 1'b0;
         mode_q_r <= MODE_WALK;
         first_r  <= 1'b1;
         led_r    <= LED_OFF;
         adv_r    <= 1'b0;
      end else begin
         adv_r <= step_s;
         if (step_s) begin
            pos_r    <= pos_nxt_s;
            dir_r    <= dir_nxt_s;
            count_r  <= count_nxt_s;
            off_r    <= off_nxt_s;
            mode_q_r <= mode_s;
            first_r  <= 1'b0;
            led_r    <= ACTIVE_LOW ? ~pat_s : pat_s;
         end
      end
   end

   assign led = led_r;
   assign adv = adv_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: one active-low and one active-high instance
// share the stimulus; every step is checked against hand-computed patterns.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       nrst;
   logic       en;
   logic [1:0] mode;
   logic [1:0] speed;
   logic [3:0] led_al, led_ah;
   logic       adv_al, adv_ah;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] cur_pat;

   logic [3:0] walk_seq   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] bounce_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0100, 4'b0010, 4'b0001, 4'b0010};

   always #5 clk = ~clk;

   led_sequencer #(.N_LED(4), .DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk   (clk),
      .nrst  (nrst),
      .en    (en),
      .mode  (mode),
      .speed (speed),
      .led   (led_al),
      .adv   (adv_al)
   );

   led_sequencer #(.N_LED(4), .DIV(4), .ACTIVE_LOW(1'b0)) dut_ah (
      .clk   (clk),
      .nrst  (nrst),
      .en    (en),
      .mode  (mode),
      .speed (speed),
      .led   (led_ah),
      .adv   (adv_ah)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Both instances against the logical pattern pat and the expected adv level.
   task automatic chk_state(input string tag, input logic adv_exp, input logic [3:0] pat);
      chk({tag, "/adv_al"}, {3'b000, adv_al}, {3'b000, adv_exp});
      chk({tag, "/adv_ah"}, {3'b000, adv_ah}, {3'b000, adv_exp});
      chk({tag, "/led_al"}, led_al, ~pat);
      chk({tag, "/led_ah"}, led_ah, pat);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         cycle();
         chk_state(tag, 1'b0, cur_pat);
      end
   endtask

   // Exactly gap cycles from the previous advance to the next one.
   task automatic expect_adv(input string tag, input int gap, input logic [3:0] pat);
      quiet(tag, gap - 1);
      cycle();
      chk_state(tag, 1'b1, pat);
      cur_pat = pat;
   endtask

   initial begin
      nrst    = 1'b0;
      en      = 1'b0;
      mode    = 2'd0;
      speed   = 2'd0;
      cur_pat = 4'b0000;

      repeat (3) cycle();
      chk_state("reset", 1'b0, 4'b0000);

      en   = 1'b1;
      nrst = 1'b1;
      for (int i = 0; i < 5; i++) expect_adv("walk", 4, walk_seq[i]);

      mode  = 2'd1;
      speed = 2'd2;
      for (int i = 0; i < 8; i++) expect_adv("bounce", 16, bounce_seq[i]);

      mode  = 2'd2;
      speed = 2'd0;
      for (int k = 0; k < 17; k++) expect_adv("binary", 4, 4'(k));

      quiet("binary_mid", 2);
      mode = 2'd3;
      expect_adv("blink_sw", 2, 4'b1111);
      expect_adv("blink", 4, 4'b0000);
      expect_adv("blink", 4, 4'b1111);

      quiet("pre_freeze", 1);
      en = 1'b0;
      quiet("freeze", 37);
      en = 1'b1;
      expect_adv("resume", 3, 4'b0000);
      expect_adv("blink_pre_rst", 4, 4'b1111);

      quiet("pre_rst", 2);
      nrst = 1'b0;
      #1;
      cur_pat = 4'b0000;
      chk_state("async_rst", 1'b0, 4'b0000);
      mode = 2'd0;
      repeat (2) cycle();
      chk_state("rst_hold", 1'b0, 4'b0000);
      nrst = 1'b1;
      expect_adv("post_rst", 4, 4'b0001);
      expect_adv("post_rst", 4, 4'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
